// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle controller and the datapath:
// instruction/flag/memory-ready inputs plus every select and strobe the controller drives.
interface mc_controller_if;
  logic       enable;
  logic [5:0] op;
  logic [5:0] func;
  logic       Z;
  logic       mem_ready;
  logic       mem_rd;
  logic       wr;
  logic       irwrite;
  logic       pcwrite;
  logic [1:0] pcsel;
  logic [1:0] wasel;
  logic [1:0] wdsel;
  logic [1:0] asel;
  logic       bsel;
  logic       sext;
  logic [4:0] alufn;
  logic       werf;
  logic [2:0] state;
  logic [1:0] err_code;

  modport master (
    input  enable, op, func, Z, mem_ready,
    output mem_rd, wr, irwrite, pcwrite, pcsel, wasel, wdsel, asel, bsel, sext,
           alufn, werf, state, err_code
  );

  modport slave (
    output enable, op, func, Z, mem_ready,
    input  mem_rd, wr, irwrite, pcwrite, pcsel, wasel, wdsel, asel, bsel, sext,
           alufn, werf, state, err_code
  );
endinterface

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// variable-latency memory handshake, illegal-instruction and memory-timeout halt.
module mc_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = $clog2(MEM_TIMEOUT + 2)
) (
  input  logic            clk,
  input  logic            reset,
  mc_controller_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {C_ALU, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JR, C_JAL} iclass_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03,
                         OP_BEQ   = 6'h04, OP_BNE   = 6'h05, OP_ADDI  = 6'h08,
                         OP_ADDIU = 6'h09, OP_SLTI  = 6'h0a, OP_SLTIU = 6'h0b,
                         OP_ANDI  = 6'h0c, OP_ORI   = 6'h0d, OP_XORI  = 6'h0e,
                         OP_LUI   = 6'h0f, OP_LW    = 6'h23, OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL  = 6'h02, FN_SRA = 6'h03, FN_SLLV = 6'h04,
                         FN_JR  = 6'h08, FN_ADD  = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22,
                         FN_AND = 6'h24, FN_OR   = 6'h25, FN_XOR = 6'h26, FN_NOR  = 6'h27,
                         FN_SLT = 6'h2a, FN_SLTU = 6'h2b;

  localparam logic [4:0] ALU_ADD = 5'b00001, ALU_SUB = 5'b10001, ALU_SLT = 5'b10011,
                         ALU_SLTU = 5'b10111, ALU_AND = 5'b00000, ALU_OR = 5'b00100,
                         ALU_XOR = 5'b01000, ALU_NOR = 5'b01100, ALU_SLL = 5'b00010,
                         ALU_SRL = 5'b01010, ALU_SRA = 5'b01110;

  localparam logic [1:0] WA_RD  = 2'b00, WA_RT  = 2'b01, WA_RA  = 2'b10;
  localparam logic [1:0] WD_PC4 = 2'b00, WD_ALU = 2'b01, WD_MEM = 2'b10;
  localparam logic [1:0] A_RS   = 2'b00, A_SHAMT = 2'b01, A_SIXTEEN = 2'b10;
  localparam logic [1:0] PC_INC = 2'b00, PC_BR  = 2'b01, PC_JMP = 2'b10, PC_REG = 2'b11;
  localparam logic [1:0] ERR_NONE = 2'b00, ERR_ILLEGAL = 2'b01, ERR_TIMEOUT = 2'b10;

  localparam bit             TIMEOUT_EN = (MEM_TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);

  state_t            state, state_nxt;
  iclass_t           iclass;
  logic              legal;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        err_code;
  logic              waiting, set_illegal, set_timeout;
  logic              rd_c, wr_c, irw_c, pcw_c, werf_c;
  logic              strobe_en;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    legal     = 1'b1;
    iclass    = C_ALU;
    bus.alufn = ALU_AND;
    bus.wasel = WA_RD;
    bus.wdsel = WD_PC4;
    bus.asel  = A_RS;
    bus.bsel  = 1'b0;
    bus.sext  = 1'b0;
    case (bus.op)
      OP_RTYPE: begin
        bus.wdsel = WD_ALU;
        case (bus.func)
          FN_ADD, FN_ADDU: bus.alufn = ALU_ADD;
          FN_SUB:          bus.alufn = ALU_SUB;
          FN_AND:          bus.alufn = ALU_AND;
          FN_OR:           bus.alufn = ALU_OR;
          FN_XOR:          bus.alufn = ALU_XOR;
          FN_NOR:          bus.alufn = ALU_NOR;
          FN_SLT:          bus.alufn = ALU_SLT;
          FN_SLTU:         bus.alufn = ALU_SLTU;
          FN_SLLV:         bus.alufn = ALU_SLL;
          FN_SLL: begin bus.alufn = ALU_SLL; bus.asel = A_SHAMT; end
          FN_SRL: begin bus.alufn = ALU_SRL; bus.asel = A_SHAMT; end
          FN_SRA: begin bus.alufn = ALU_SRA; bus.asel = A_SHAMT; end
          FN_JR:  begin iclass = C_JR; bus.wdsel = WD_PC4; end
          default: begin legal = 1'b0; bus.wdsel = WD_PC4; end
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        bus.wasel = WA_RT;
        bus.wdsel = WD_ALU;
        bus.bsel  = 1'b1;
        case (bus.op)
          OP_ADDI, OP_ADDIU: begin bus.alufn = ALU_ADD;  bus.sext = 1'b1; end
          OP_SLTI:           begin bus.alufn = ALU_SLT;  bus.sext = 1'b1; end
          OP_SLTIU:          begin bus.alufn = ALU_SLTU; bus.sext = 1'b1; end
          OP_ANDI:           bus.alufn = ALU_AND;
          OP_ORI:            bus.alufn = ALU_OR;
          OP_XORI:           bus.alufn = ALU_XOR;
          // LUI: shift the zero-extended immediate left by a constant 16
          default:     begin bus.alufn = ALU_SLL;  bus.asel = A_SIXTEEN; end
        endcase
      end
      OP_LW: begin
        iclass = C_LW; bus.alufn = ALU_ADD; bus.bsel = 1'b1; bus.sext = 1'b1;
        bus.wasel = WA_RT; bus.wdsel = WD_MEM;
      end
      OP_SW:  begin iclass = C_SW;  bus.alufn = ALU_ADD; bus.bsel = 1'b1; bus.sext = 1'b1; end
      OP_BEQ: begin iclass = C_BEQ; bus.alufn = ALU_SUB; bus.sext = 1'b1; end
      OP_BNE: begin iclass = C_BNE; bus.alufn = ALU_SUB; bus.sext = 1'b1; end
      OP_J:   iclass = C_J;
      OP_JAL: begin iclass = C_JAL; bus.wasel = WA_RA; bus.wdsel = WD_PC4; end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    rd_c        = 1'b0;
    wr_c        = 1'b0;
    irw_c       = 1'b0;
    pcw_c       = 1'b0;
    werf_c      = 1'b0;
    bus.pcsel   = PC_INC;
    waiting     = 1'b0;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    case (state)
      S_FETCH: begin
        rd_c    = 1'b1;
        waiting = 1'b1;
        if (bus.mem_ready) begin
          irw_c     = 1'b1;
          pcw_c     = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (legal) state_nxt = S_EXEC;
        else begin
          state_nxt   = S_HALT;
          set_illegal = 1'b1;
        end
      end
      S_EXEC: begin
        state_nxt = S_FETCH;
        case (iclass)
          C_ALU:       state_nxt = S_WB;
          C_LW, C_SW:  state_nxt = S_MEM;
          C_BEQ: begin pcw_c = bus.Z;  bus.pcsel = PC_BR;  end
          C_BNE: begin pcw_c = ~bus.Z; bus.pcsel = PC_BR;  end
          C_J:   begin pcw_c = 1'b1;   bus.pcsel = PC_JMP; end
          C_JR:  begin pcw_c = 1'b1;   bus.pcsel = PC_REG; end
          C_JAL: begin pcw_c = 1'b1;   bus.pcsel = PC_JMP; werf_c = 1'b1; end
          default: state_nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        waiting = 1'b1;
        if (iclass == C_SW) wr_c = 1'b1;
        else                rd_c = 1'b1;
        if (bus.mem_ready) state_nxt = (iclass == C_SW) ? S_FETCH : S_WB;
      end
      S_WB: begin
        werf_c    = 1'b1;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_HALT;
    endcase
    // An accept on the limit cycle takes priority over the timeout
    if (TIMEOUT_EN && waiting && !bus.mem_ready && cnt == CNT_LIMIT) begin
      state_nxt   = S_HALT;
      set_timeout = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_FETCH;
      cnt      <= '0;
      err_code <= ERR_NONE;
    end else if (bus.enable) begin
      state <= state_nxt;
      if (state_nxt != state)          cnt <= '0;
      else if (waiting && cnt != '1)   cnt <= cnt + CNT_W'(1);
      if (set_illegal)      err_code <= ERR_ILLEGAL;
      else if (set_timeout) err_code <= ERR_TIMEOUT;
    end
  end

  // Strobes vanish while frozen or in reset, so a reset mid-write never leaks a request
  assign strobe_en    = bus.enable & ~reset;
  assign bus.mem_rd   = rd_c   & strobe_en;
  assign bus.wr       = wr_c   & strobe_en;
  assign bus.irwrite  = irw_c  & strobe_en;
  assign bus.pcwrite  = pcw_c  & strobe_en;
  assign bus.werf     = werf_c & strobe_en;
  assign bus.state    = state;
  assign bus.err_code = err_code;

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control FSM for the MIPS datapath, generalising the single-cycle decoder into a sequenced controller. Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, and handshakes with a variable-latency memory. It detects illegal instructions and memory timeouts, and drives all datapath selects and write strobes. Sits between the instruction register/ALU flags and the datapath muxes in the multicycle CPU top.

## Interface

Parameters:
- MEM_TIMEOUT, 15: maximum wait cycles for mem_ready in FETCH/MEM before halting; 0 disables the timeout.
- CNT_W, $clog2(MEM_TIMEOUT+2): wait-counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- enable  in  1  0 freezes state and counter and forces all strobes to 0.
- op  in  6  opcode from the instruction register.
- func  in  6  R-type func from the instruction register.
- Z  in  1  ALU zero flag.
- mem_ready  in  1  memory accepts the current request this cycle.
- mem_rd  out  1  read request; held until accepted.
- wr  out  1  write request; held until accepted.
- irwrite  out  1  load the instruction register.
- pcwrite  out  1  update the PC.
- pcsel  out  2  00 PC+4, 01 branch, 10 jump, 11 register (JR).
- wasel, wdsel, asel  out  2 each  datapath selects, same encodings as the single-cycle CPU.
- bsel, sext  out  1 each  B-operand select and sign-extend.
- alufn  out  5  ALU function.
- werf  out  1  register-file write.
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- err_code  out  2  00 none, 01 illegal instruction, 10 memory timeout; sticky until reset.

## Operation

- Strobes are mem_rd, wr, irwrite, pcwrite and werf.
  - They are combinational from state, op, func, Z and mem_ready.
  - They are ANDed with enable and with ~reset.
- Selects and alufn are combinational from op/func. Don't-care bits are driven 0.
- alufn values:
  - add group (ADD, ADDU, ADDI, ADDIU, LW, SW): 00001
  - SUB, BEQ, BNE: 10001
  - SLT, SLTI: 10011
  - SLTU, SLTIU: 10111
  - AND, ANDI: 00000
  - OR, ORI: 00100
  - XOR, XORI: 01000
  - NOR: 01100
  - SLL, SLLV, LUI: 00010
  - SRL: 01010
  - SRA: 01110
- FETCH:
  - mem_rd=1.
  - When mem_ready: irwrite=1, pcwrite=1, pcsel=00, go to DECODE.
  - Otherwise stay and increment the counter.
- DECODE:
  - Unknown op, or op=0 with unknown func: go to HALT with err_code=01.
  - Otherwise go to EXEC.
- EXEC, by instruction class:
  - ALU and immediate ops: go to WB.
  - LW, SW: go to MEM.
  - BEQ/BNE: pcwrite=(BEQ&Z)|(BNE&~Z), pcsel=01, go to FETCH.
  - J: pcwrite=1, pcsel=10, go to FETCH.
  - JR: pcwrite=1, pcsel=11, go to FETCH.
  - JAL: pcwrite=1, pcsel=10, werf=1, wasel=10, wdsel=00, go to FETCH.
- MEM:
  - LW: mem_rd=1 until mem_ready, then go to WB.
  - SW: wr=1 until mem_ready, then go to FETCH. The write commits only on the wr&mem_ready cycle. werf is never asserted for SW.
- WB: werf=1, go to FETCH.
- Counter:
  - Clears on every state change.
  - If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT while waiting, with mem_ready low: go to HALT with err_code=10.
  - mem_ready on that same cycle wins: no error, normal transition.
- HALT: all strobes 0, state held; only reset exits.

## Timing

- Reset values: state=FETCH, counter=0, err_code=00.
  - All strobes are 0 while reset is high.
  - mem_rd rises the first cycle after reset deasserts.
- Latency with zero-wait memory:
  - R-type and immediate ops: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - Branches and jumps: 3 cycles.
- Each memory wait cycle adds 1 cycle.
- Transitions happen on rising clk only when enable=1.
  - With enable=0, the request strobes still drop to 0.
  - The request re-asserts when enable returns.
- Asynchronous reset mid-instruction, including in HALT, returns to FETCH immediately. No partial write is issued.

## Test plan

- Reset, then ADD (op=0, func=100000) with mem_ready=1: states 0,1,2,4,0; werf=1 only in WB; alufn=00001; wasel=00.
- LW with mem_ready low for 3 cycles in MEM: mem_rd held 3 cycles; WB follows the accept; total 8 cycles; wr never 1.
- BEQ with Z=1, then BNE with Z=1: pcwrite=1 and pcsel=01 in EXEC for BEQ; pcwrite=0 for BNE.
- SW: wr=1 in MEM only; werf=0 throughout; enable dropped mid-MEM forces wr=0 and freezes state=3.
- op=111111: DECODE goes to HALT, err_code=01, strobes stay 0 for 20 cycles; reset restores FETCH and err_code=00.
- MEM_TIMEOUT=4 with mem_ready stuck low in FETCH: HALT with err_code=10 after 5 FETCH cycles. mem_ready rising on the limit cycle gives DECODE instead.
